// File: rtl/lat_data_memory.sv
// Latency-configurable byte-addressable data memory: one outstanding load/store,
// byte/half/word lanes with sign/zero extension, self-clearing after reset.
module lat_data_memory #(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;

  state_t         state;
  logic [AW-1:0]  clr_idx;
  logic [CW-1:0]  lat_cnt;

  logic           write_p0;
  logic [1:0]     size_p0;
  logic           uns_p0;
  logic [AW-1:0]  idx_p0;
  logic [1:0]     off_p0;
  logic [31:0]    wdata_p0;

  logic [31:0]    mem [MEM_DEPTH];
  logic [31:0]    rd_word;
  logic           vld_p0;
  logic           done_p0;
  logic           err_p0;

  logic           mem_we;
  logic [AW-1:0]  mem_idx;
  logic [3:0]     mem_be;
  logic [31:0]    mem_wd;

  logic           unused_addr_bits;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = |off;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicating the right-aligned store data puts it on every lane; the mask picks one.
  function automatic logic [31:0] place_store(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   place_store = {4{wdata[7:0]}};
      2'b01:   place_store = {2{wdata[15:0]}};
      default: place_store = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign vld_p0  = req_valid && req_ready;
  assign done_p0 = (state == BUSY) && (lat_cnt == CW'(LATENCY));
  assign err_p0  = is_misaligned(size_p0, off_p0);
  assign rd_word = mem[idx_p0];

  // Stage p0: request capture at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      write_p0 <= req_write;
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      idx_p0   <= req_addr[AW+1:2];
      off_p0   <= req_addr[1:0];
      wdata_p0 <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      lat_cnt    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(MEM_DEPTH - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (vld_p0) begin
            state     <= BUSY;
            req_ready <= 1'b0;
            lat_cnt   <= CW'(1);
          end
        end
        BUSY: begin
          // Stage p1: the LATENCY-th edge after acceptance executes and responds.
          if (done_p0) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_err   <= err_p0;
            resp_rdata <= (err_p0 || write_p0) ? '0
                                                : load_extend(rd_word, size_p0, off_p0, uns_p0);
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_idx = idx_p0;
    mem_be  = lane_mask(size_p0, off_p0);
    mem_wd  = place_store(size_p0, wdata_p0);
    if (state == CLEAR) begin
      mem_we  = 1'b1;
      mem_idx = clr_idx;
      mem_be  = 4'hF;
      mem_wd  = '0;
    end else if (done_p0 && write_p0 && !err_p0) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
  end

endmodule
